output_buffer: RTL



---
 rtl/output_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/output_buffer.sv
// output_buffer: realigns the column-skewed partial-sum stream of the systolic array into rows.
// Latency: a row is presented the cycle after its last column is written; o_data is fall-through.
// Backpressure: o_ready low holds the head row; i_ready is advisory, writes into a full column are dropped.
// Option: define OUTPUT_BUFFER_RELU_EN to clamp negative o_data elements to zero (storage stays raw).
module output_buffer #(
  parameter int SYS_COLS   = 4,
  parameter int P_BITWIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [SYS_COLS-1:0]            i_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0] i_data,
  output logic                           i_ready,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [SYS_COLS*P_BITWIDTH-1:0] o_data,
  output logic [$clog2(DEPTH):0]         row_count,
  output logic                           overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  // Per-column circular storage; contents are don't-care after a flush.
  logic [P_BITWIDTH-1:0] mem [SYS_COLS][DEPTH];
  // Write pointers carry one extra wrap bit so full and empty differ.
  logic [PW-1:0]         wptr [SYS_COLS];
  // Single read pointer: every column pops its head together.
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         occ [SYS_COLS];
  logic [SYS_COLS-1:0]   wr_en;
  logic [SYS_COLS-1:0]   wr_drop;
  logic [P_BITWIDTH-1:0] head;
  logic                  pop;
  logic                  flush;

  assign flush = rst | clr;

  // Column occupancy against the shared read pointer and write accept/drop decisions.
  always_comb begin
    for (int c = 0; c < SYS_COLS; c++) begin
      occ[c]     = wptr[c] - rptr;
      wr_en[c]   = i_valid[c] && (occ[c] != FULL);
      wr_drop[c] = i_valid[c] && (occ[c] == FULL);
    end
  end

  // A row is complete once the last (most lagging) column holds it.
  assign row_count = occ[SYS_COLS-1];
  assign o_valid   = (occ[SYS_COLS-1] != '0);
  assign i_ready   = (occ[0] != FULL);
  assign pop       = o_valid & o_ready;

  // Write pointers advance only on accepted writes; a pop never frees a same-cycle slot.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int c = 0; c < SYS_COLS; c++) begin
        wptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < SYS_COLS; c++) begin
        if (wr_en[c]) begin
          wptr[c] <= wptr[c] + PW'(1);
        end
      end
    end
  end

  // Shared read pointer steps on every accepted handshake.
  always_ff @(posedge clk) begin
    if (flush) begin
      rptr <= '0;
    end else if (pop) begin
      rptr <= rptr + PW'(1);
    end
  end

  // Sticky drop flag, cleared only by a flush.
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow <= 1'b0;
    end else if (wr_drop != '0) begin
      overflow <= 1'b1;
    end
  end

  // Storage write port per column; a flush discards any partially written row.
  always_ff @(posedge clk) begin
    for (int c = 0; c < SYS_COLS; c++) begin
      if (!flush && wr_en[c]) begin
        mem[c][wptr[c][AW-1:0]] <= i_data[c*P_BITWIDTH +: P_BITWIDTH];
      end
    end
  end

  // Fall-through head row, zeroed when nothing complete is stored.
  always_comb begin
    o_data = '0;
    head   = '0;
    for (int c = 0; c < SYS_COLS; c++) begin
      head = mem[c][rptr[AW-1:0]];
`ifdef OUTPUT_BUFFER_RELU_EN
      if (head[P_BITWIDTH-1]) begin
        head = '0;
      end
`endif
      if (o_valid) begin
        o_data[c*P_BITWIDTH +: P_BITWIDTH] = head;
      end
    end
  end

endmodule
